imm_issue_ctrl: RTL and testbench
=================================

# imm_issue_ctrl

ID-stage immediate issue controller for the pipelined MIPS core. It decodes each instruction's opcode to pick the immediate extension mode: sign, zero, upper or none. It forms the extended immediate and the branch target, and holds the results in a 2-entry elastic buffer with valid/ready handshakes on both sides. It sits between the IF/ID register and the ID/EX register, so back-pressure from EX/hazard logic never drops or duplicates an immediate.

## Interface
Parameters:
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and incoming entries (branch taken / exception)
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  controller accepts this cycle
- in_instr  in  32  instruction word
- in_pc_plus4  in  32  PC+4 of that instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head this cycle
- out_imm  out  32  extended immediate
- out_br_target  out  32  in_pc_plus4 + (sign-extended imm << 2), mod 2^32
- out_kind  out  2  0 SIGN, 1 ZERO, 2 UPPER, 3 NONE
- out_opcode  out  6  instr[31:26] passthrough
- out_illegal  out  1  opcode not in the decode list

## Operation
- Decode of instr[31:26]:
  - SIGN: 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0B, 0x23, 0x2B
  - ZERO: 0x0C, 0x0D, 0x0E
  - UPPER: 0x0F
  - NONE: 0x00, 0x02, 0x03
  - anything else: NONE with illegal=1
- Immediate rules, with imm = instr[15:0]:
  - SIGN: {16{imm[15]}, imm}
  - ZERO: {16'h0, imm}
  - UPPER: {imm, 16'h0}
  - NONE: 32'h0
- out_br_target is always computed from the sign-extended imm regardless of kind; wrap-around is silent.
- Decode and arithmetic happen at enqueue. Entries store the computed fields, never the raw instr.
- Buffer FSM, with occupancy state:
  - EMPTY: push → ONE.
  - ONE: push only → TWO; pop only → EMPTY; push+pop → ONE, with the new entry becoming head.
  - TWO: pop → ONE; push impossible.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (state != TWO). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_* fields show the head entry and are registered, not decoded from in_instr.
- Order is strictly FIFO.
- flush: next state EMPTY. It takes priority over a simultaneous push and pop; the incoming instruction is dropped.
- rst: same as flush, and all entry storage is cleared to 0.

## Timing
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_br_target=0, out_kind=0, out_opcode=0, out_illegal=0.
- in_ready is high in the first cycle after reset release.
- Latency: an instruction accepted in cycle N is visible at out_* in cycle N+1 when the buffer was empty or became empty by a pop in N.
- Throughput: one per cycle with out_ready held high.
- Stall: with out_ready=0, at most 2 instructions are accepted. in_ready falls the cycle after the second push.
- Flush asserted in cycle N gives out_valid=0 and in_ready=1 in N+1.
- Reset mid-operation behaves the same as flush.
- Head outputs stay stable while out_valid=1 & out_ready=0.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams (OP_RTYPE, OP_BEQ, OP_LUI, …)
  - imm-kind encodings IMM_SIGN/ZERO/UPPER/NONE
  - entry width constant (32+32+2+6+1 = 73)
- Sub-module `imm_decode`: purely combinational; instr and pc_plus4 in, kind/imm/br_target/illegal out.
- The top level holds the 2-entry register array, head pointer/state FSM and handshake logic.

## Test plan
- addi, imm 0xFFFC, pc_plus4 0x00000100 → out_imm 0xFFFFFFFC, kind 0, out_br_target 0x000000F0, 1-cycle latency.
- ori imm 0x8000 → out_imm 0x00008000, kind 1. lui imm 0x1234 → out_imm 0x12340000, kind 2. Opcode 0x3F → kind 3, illegal=1, out_imm 0.
- beq, imm 0x0002, pc_plus4 0xFFFFFFFC → out_br_target 0x00000004 (wrap).
- out_ready=0 for 4 cycles with a stream A,B,C → A and B accepted, in_ready=0 from the third cycle, C held upstream. Release gives the order A,B,C with no loss or duplication.
- Buffer at TWO, flush with in_valid=1 → next cycle out_valid=0, in_ready=1, incoming instruction never appears.
- Continuous stream of 8 instructions with out_ready=1 → one output per cycle, push+pop in ONE keeps state ONE. rst pulsed mid-stream → all outputs at reset values next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, immediate-kind encodings and the
// layout of one issue-buffer entry.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_NONE  = 2'd3
  } imm_kind_e;

  localparam int unsigned ENTRY_W = 32 + 32 + 2 + 6 + 1;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] br_target;
    imm_kind_e   kind;
    logic [5:0]  opcode;
    logic        illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode decode: picks the immediate extension mode and forms
// the extended immediate and branch target.
module imm_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output imm_kind_e   kind,
  output logic [31:0] imm,
  output logic [31:0] br_target,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [15:0] raw;
  logic [31:0] sext;
  logic        unused_fields;

  assign opcode        = instr[31:26];
  assign raw           = instr[15:0];
  assign sext          = {{16{raw[15]}}, raw};
  assign unused_fields = ^instr[25:16];

  always_comb begin
    kind    = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_SLTIU, OP_LW, OP_SW:    kind = IMM_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:           kind = IMM_ZERO;
      OP_LUI:                             kind = IMM_UPPER;
      OP_RTYPE, OP_J, OP_JAL:             kind = IMM_NONE;
      default:                            illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (kind)
      IMM_SIGN:  imm = sext;
      IMM_ZERO:  imm = {16'h0000, raw};
      IMM_UPPER: imm = {raw, 16'h0000};
      IMM_NONE:  imm = '0;
      default:   imm = '0;
    endcase
  end

  // Target uses the sign-extended immediate for every kind; overflow wraps.
  assign br_target = pc_plus4 + {sext[29:0], 2'b00};

endmodule

// File: rtl/imm_issue_ctrl.sv
// ID-stage immediate issue controller: decodes at enqueue and holds results in
// a 2-entry elastic buffer with valid/ready handshakes on both sides.
module imm_issue_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc_plus4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_br_target,
  output logic [1:0]      out_kind,
  output logic [5:0]      out_opcode,
  output logic            out_illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e     state_q, state_d;
  imm_entry_t entry_q [DEPTH];
  imm_entry_t new_entry;
  imm_entry_t head_entry;
  logic       head_q, head_d;
  logic       wr_idx;
  logic       push, pop;

  imm_decode u_decode (
    .instr     (in_instr),
    .pc_plus4  (in_pc_plus4),
    .kind      (new_entry.kind),
    .imm       (new_entry.imm),
    .br_target (new_entry.br_target),
    .illegal   (new_entry.illegal)
  );

  assign new_entry.opcode = in_instr[31:26];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // With one entry held, the free slot is the one opposite the head.
  assign wr_idx = (state_q == StOne) ? ~head_q : head_q;
  assign head_d = pop ? ~head_q : head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop) begin
            state_d = StTwo;
          end else if (pop && !push) begin
            state_d = StEmpty;
          end
        end
        StTwo:   if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (!flush) begin
      head_q <= head_d;
      if (push) begin
        entry_q[wr_idx] <= new_entry;
      end
    end
  end

  assign head_entry    = entry_q[head_q];
  assign out_imm       = head_entry.imm;
  assign out_br_target = head_entry.br_target;
  assign out_kind      = head_entry.kind;
  assign out_opcode    = head_entry.opcode;
  assign out_illegal   = head_entry.illegal;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Self-checking bench for imm_issue_ctrl: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_imm_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc_plus4, out_imm, out_br_target;
  logic [1:0]  out_kind;
  logic [5:0]  out_opcode;

  always #5 clk = ~clk;

  imm_issue_ctrl #(.DEPTH(2), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc_plus4   (in_pc_plus4),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_imm       (out_imm),
    .out_br_target (out_br_target),
    .out_kind      (out_kind),
    .out_opcode    (out_opcode),
    .out_illegal   (out_illegal)
  );

  typedef struct {
    logic [31:0] imm;
    logic [31:0] bt;
    logic [1:0]  kind;
    logic [5:0]  op;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   zero_flag = 1'b0;
  logic [5:0] op_tab [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                              6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};

  function automatic exp_t ref_entry(input logic [31:0] instr, input logic [31:0] pc);
    exp_t        e;
    logic [5:0]  op;
    logic [31:0] s;
    op = instr[31:26];
    s  = 32'($signed(instr[15:0]));
    e.op  = op;
    e.ill = 1'b0;
    e.bt  = pc + s * 32'd4;
    if (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B}) begin
      e.kind = 2'd0;
      e.imm  = s;
    end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      e.kind = 2'd1;
      e.imm  = {16'h0, instr[15:0]};
    end else if (op == 6'h0F) begin
      e.kind = 2'd2;
      e.imm  = {instr[15:0], 16'h0};
    end else begin
      e.kind = 2'd3;
      e.imm  = 32'h0;
      e.ill  = !(op inside {6'h00, 6'h02, 6'h03});
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check against the model mid-cycle, then advance it.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic rs);
    bit   push, pop;
    exp_t h;
    in_valid    = v;
    in_instr    = ins;
    in_pc_plus4 = pc;
    out_ready   = rdy;
    flush       = fl;
    rst         = rs;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      chk("out_imm", out_imm, h.imm);
      chk("out_br_target", out_br_target, h.bt);
      chk("out_kind", 32'(out_kind), 32'(h.kind));
      chk("out_opcode", 32'(out_opcode), 32'(h.op));
      chk("out_illegal", 32'(out_illegal), 32'(h.ill));
    end else if (zero_flag) begin
      chk("rst_imm", out_imm, 32'h0);
      chk("rst_br_target", out_br_target, 32'h0);
      chk("rst_fields", {23'h0, out_kind, out_opcode, out_illegal}, 32'h0);
    end
    push = v && (q.size() < 2);
    pop  = rdy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      zero_flag = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(ref_entry(ins, pc));
        zero_flag = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 15)];
    return {op, 26'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc_plus4 = '0;
    repeat (2) @(posedge clk);
    #1;
    zero_flag = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // addi sign-extension, 1-cycle latency
    cycle(1'b1, {6'h08, 10'h0, 16'hFFFC}, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFC);
    chk("addi_kind", 32'(out_kind), 32'h0);
    chk("addi_bt", out_br_target, 32'h0000_00F0);
    cycle(1'b1, {6'h0D, 10'h0, 16'h8000}, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ori_imm", out_imm, 32'h0000_8000);
    chk("ori_kind", 32'(out_kind), 32'h1);
    cycle(1'b1, {6'h0F, 10'h0, 16'h1234}, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("lui_imm", out_imm, 32'h1234_0000);
    chk("lui_kind", 32'(out_kind), 32'h2);
    cycle(1'b1, {6'h3F, 10'h3FF, 16'h5555}, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("illegal_kind", 32'(out_kind), 32'h3);
    chk("illegal_flag", 32'(out_illegal), 32'h1);
    chk("illegal_imm", out_imm, 32'h0);
    cycle(1'b1, {6'h04, 10'h0, 16'h0002}, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    chk("beq_wrap_bt", out_br_target, 32'h0000_0004);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Stall: A, B accepted, C held upstream, then drained in order
    cycle(1'b1, {6'h08, 10'h0, 16'h000A}, 32'h10, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {6'h09, 10'h0, 16'h000B}, 32'h20, 1'b0, 1'b0, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    cycle(1'b1, {6'h0C, 10'h0, 16'h000C}, 32'h30, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {6'h0C, 10'h0, 16'h000C}, 32'h30, 1'b0, 1'b0, 1'b0);
    chk("stall_head_a", out_imm, 32'h0000_000A);
    cycle(1'b1, {6'h0C, 10'h0, 16'h000C}, 32'h30, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, {6'h0C, 10'h0, 16'h000C}, 32'h30, 1'b1, 1'b0, 1'b0);
    chk("stall_head_c", out_opcode, 6'h0C);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with buffer full and a new instruction offered
    cycle(1'b1, {6'h23, 10'h0, 16'h0100}, 32'h40, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {6'h2B, 10'h0, 16'h0200}, 32'h50, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {6'h0E, 10'h0, 16'h0300}, 32'h60, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, rand_instr(), $urandom, 1'b1, 1'b0, 1'b0);
      chk("stream_valid", 32'(out_valid), 32'h1);
    end
    cycle(1'b1, rand_instr(), $urandom, 1'b1, 1'b0, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_bt", out_br_target, 32'h0);
    chk("rst_out_misc", {23'h0, out_kind, out_opcode, out_illegal}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
